// File: rtl/uart_core_pkg.sv
// Shared UART types and default timing constants.
package uart_core_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  localparam int unsigned UART_CLK_FREQ    = 5000000;
  localparam int unsigned UART_BAUD_RATE   = 9600;
  localparam int unsigned UART_OVERSAMPLE  = 16;
  localparam int unsigned UART_DATA_BITS   = 8;
  localparam int unsigned UART_RX_MID_TICK = 7;

  // Rounded clocks-per-tick divisor.
  function automatic int unsigned div_round(input int unsigned clk_hz,
                                            input int unsigned baud,
                                            input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  localparam int unsigned UART_DIV =
    div_round(UART_CLK_FREQ, UART_BAUD_RATE, UART_OVERSAMPLE);

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick divider shared by TX and RX.
module uart_baud_gen
  import uart_core_pkg::*;
#(
  parameter int unsigned DIV = UART_DIV
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver with 2-flop input synchronizer and mid-start glitch rejection.
module uart_rx
  import uart_core_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx_data_input,
  output logic                 o_done_bit_rx,
  output logic [DATA_BITS-1:0] o_data_byte
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);

  rx_state_e            state_q;
  logic [1:0]           sync_q;
  logic [TW-1:0]        tick_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= RX_IDLE;
      sync_q  <= '1;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_rx_data_input};
      done_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            tick_q  <= '0;
            state_q <= RX_START;
          end
        end
        RX_START: begin
          if (i_tick) begin
            if (tick_q == TW'(UART_RX_MID_TICK - 1)) begin
              tick_q  <= '0;
              bit_q   <= '0;
              state_q <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        RX_DATA: begin
          if (i_tick) begin
            if (tick_q == TW'(OVERSAMPLE - 1)) begin
              tick_q  <= '0;
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              bit_q   <= bit_q + BW'(1);
              if (bit_q == BW'(DATA_BITS - 1)) begin
                state_q <= RX_STOP;
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        RX_STOP: begin
          // Stop level is not checked; a low stop bit still delivers the byte.
          if (i_tick) begin
            if (tick_q == TW'(OVERSAMPLE - 1)) begin
              tick_q  <= '0;
              data_q  <= shift_q;
              done_q  <= 1'b1;
              state_q <= RX_IDLE;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign o_done_bit_rx = done_q;
  assign o_data_byte   = data_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter; each bit is held for OVERSAMPLE ticks.
module uart_tx
  import uart_core_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_tx_signal,
  input  logic [DATA_BITS-1:0] i_data_byte,
  output logic                 o_tx_data,
  output logic                 o_done_bit_tx
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);

  tx_state_e            state_q;
  logic [TW-1:0]        tick_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q;
  logic                 done_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= TX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (i_tx_signal) begin
            shift_q <= i_data_byte;
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (i_tick) begin
            if (tick_q == TW'(OVERSAMPLE - 1)) begin
              tick_q  <= '0;
              tx_q    <= shift_q[0];
              state_q <= TX_DATA;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        TX_DATA: begin
          if (i_tick) begin
            if (tick_q == TW'(OVERSAMPLE - 1)) begin
              tick_q <= '0;
              if (bit_q == BW'(DATA_BITS - 1)) begin
                tx_q    <= 1'b1;
                state_q <= TX_STOP;
              end else begin
                // Next bit is taken from the pre-shift value so it lands on the line now.
                bit_q   <= bit_q + BW'(1);
                shift_q <= shift_q >> 1;
                tx_q    <= shift_q[1];
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        TX_STOP: begin
          tx_q <= 1'b1;
          if (i_tick) begin
            if (tick_q == TW'(OVERSAMPLE - 1)) begin
              tick_q  <= '0;
              done_q  <= 1'b1;
              state_q <= TX_IDLE;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign o_tx_data     = tx_q;
  assign o_done_bit_tx = done_q;

endmodule

// File: rtl/uart_core.sv
// UART top: baud tick generator shared by independent TX and RX engines.
module uart_core
  import uart_core_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = UART_CLK_FREQ,
  parameter int unsigned BAUD_RATE  = UART_BAUD_RATE,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_tx_signal,
  input  logic [7:0] i_data_byte,
  input  logic       i_rx_data_input,
  output logic       o_tick,
  output logic       o_tx_data,
  output logic       o_done_bit_tx,
  output logic       o_done_bit_rx,
  output logic [7:0] o_data_byte
);

  localparam int unsigned DIV = div_round(CLK_FREQ, BAUD_RATE, OVERSAMPLE);

  logic tick;

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  uart_tx #(
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS (DATA_BITS)
  ) u_tx (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_tick        (tick),
    .i_tx_signal   (i_tx_signal),
    .i_data_byte   (i_data_byte),
    .o_tx_data     (o_tx_data),
    .o_done_bit_tx (o_done_bit_tx)
  );

  uart_rx #(
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS (DATA_BITS)
  ) u_rx (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_tick          (tick),
    .i_rx_data_input (i_rx_data_input),
    .o_done_bit_rx   (o_done_bit_rx),
    .o_data_byte     (o_data_byte)
  );

  assign o_tick = tick;

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: loopback, back-to-back, glitch and reset-abort cases.
module tb_uart_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_sig;
  logic [7:0] data_in;
  logic       rx_line;
  logic       loop_en;
  logic       rx_drive;
  logic       tick;
  logic       tx_line;
  logic       done_tx;
  logic       done_rx;
  logic [7:0] data_out;

  int n_cmp = 0;
  int n_fail = 0;
  int rx_done_cnt = 0;
  int tx_done_cnt = 0;

  logic [7:0] rx_exp_q[$];
  logic       wave_q[$];
  bit         wave_arm = 1'b0;
  bit         wave_started = 1'b0;
  int         wave_tick = 0;

  always #5 clk = ~clk;

  assign rx_line = loop_en ? tx_line : rx_drive;

  uart_core #(
    .CLK_FREQ  (5000000),
    .BAUD_RATE (9600),
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_tx_signal     (tx_sig),
    .i_data_byte     (data_in),
    .i_rx_data_input (rx_line),
    .o_tick          (tick),
    .o_tx_data       (tx_line),
    .o_done_bit_tx   (done_tx),
    .o_done_bit_rx   (done_rx),
    .o_data_byte     (data_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RX scoreboard: every done pulse pops one expected byte.
  always @(negedge clk) begin
    if (done_tx) tx_done_cnt++;
    if (done_rx) begin
      rx_done_cnt++;
      if (rx_exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rx_unexpected: got byte 0x%0h, expected no rx done pulse (t=%0t)", data_out, $time);
      end else begin
        check("rx_byte", 32'(data_out), 32'(rx_exp_q.pop_front()));
      end
    end
  end

  // TX waveform monitor: sample the line at tick 8 of every 16-tick bit.
  always @(negedge clk) begin
    if (wave_arm) begin
      if (!wave_started && tx_line == 1'b0) begin
        wave_started = 1'b1;
        wave_tick = 0;
      end
      if (wave_started && tick) begin
        wave_tick++;
        if (wave_tick % 16 == 8 && wave_q.size() > 0)
          check("tx_bit", 32'(tx_line), 32'(wave_q.pop_front()));
        if (wave_q.size() == 0) begin
          wave_arm = 1'b0;
          wave_started = 1'b0;
        end
      end
    end
  end

  task automatic wait_rx(input int target, input int limit, input string name);
    int n = 0;
    while (rx_done_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(rx_done_cnt >= target), 32'd1);
  endtask

  task automatic wait_tx(input int target, input int limit, input string name);
    int n = 0;
    while (tx_done_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(tx_done_cnt >= target), 32'd1);
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    data_in = b;
    tx_sig  = 1'b1;
    repeat (hold) @(negedge clk);
    tx_sig  = 1'b0;
  endtask

  task automatic tick_period(input string name);
    int n = 0;
    int p = 1;
    while (!tick && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    while (!tick && p < 100) begin
      @(negedge clk);
      p++;
    end
    check(name, 32'(p), 32'd33);
  endtask

  initial begin
    logic aa_bits[10];
    int base_rx;
    int base_tx;
    aa_bits = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; tx_sig = 1'b0; data_in = 8'h00; loop_en = 1'b1; rx_drive = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_line", 32'(tx_line), 32'd1);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_done_tx", 32'(done_tx), 32'd0);
    check("reset_done_rx", 32'(done_rx), 32'd0);
    check("reset_data_byte", 32'(data_out), 32'h00);
    rst = 1'b0;
    tick_period("tick_period_a");
    tick_period("tick_period_b");

    // Loopback 0xAA with waveform check.
    base_rx = rx_done_cnt; base_tx = tx_done_cnt;
    foreach (aa_bits[i]) wave_q.push_back(aa_bits[i]);
    wave_arm = 1'b1;
    rx_exp_q.push_back(8'hAA);
    send(8'hAA, 50);
    wait_rx(base_rx + 1, 5808 - 50, "aa_rx_within_11_bits");
    wait_tx(base_tx + 1, 2000, "aa_tx_done");
    repeat (300) @(negedge clk);
    check("aa_tx_done_count", 32'(tx_done_cnt - base_tx), 32'd1);
    check("aa_rx_done_count", 32'(rx_done_cnt - base_rx), 32'd1);
    check("aa_wave_consumed", 32'(wave_q.size()), 32'd0);
    check("aa_data_byte", 32'(data_out), 32'hAA);

    // Back-to-back 0x00 then 0xFF with request held through the first frame.
    base_rx = rx_done_cnt; base_tx = tx_done_cnt;
    rx_exp_q.push_back(8'h00);
    rx_exp_q.push_back(8'hFF);
    data_in = 8'h00; tx_sig = 1'b1;
    repeat (50) @(negedge clk);
    data_in = 8'hFF;
    wait_tx(base_tx + 1, 6000, "b2b_first_tx_done");
    @(negedge clk);
    tx_sig = 1'b0;
    wait_rx(base_rx + 2, 7000, "b2b_rx_two");
    wait_tx(base_tx + 2, 7000, "b2b_second_tx_done");
    repeat (300) @(negedge clk);
    check("b2b_tx_done_count", 32'(tx_done_cnt - base_tx), 32'd2);
    check("b2b_rx_done_count", 32'(rx_done_cnt - base_rx), 32'd2);
    check("b2b_last_byte", 32'(data_out), 32'hFF);

    // Data change mid-frame is ignored.
    base_rx = rx_done_cnt; base_tx = tx_done_cnt;
    rx_exp_q.push_back(8'h3C);
    send(8'h3C, 2);
    repeat (1000) @(negedge clk);
    data_in = 8'h55; tx_sig = 1'b1;
    repeat (100) @(negedge clk);
    tx_sig = 1'b0;
    wait_rx(base_rx + 1, 6000, "mid_rx_done");
    wait_tx(base_tx + 1, 6000, "mid_tx_done");
    repeat (600) @(negedge clk);
    check("mid_tx_done_count", 32'(tx_done_cnt - base_tx), 32'd1);
    check("mid_data_byte", 32'(data_out), 32'h3C);

    // 3-tick low glitch is rejected.
    base_rx = rx_done_cnt;
    loop_en = 1'b0; rx_drive = 1'b1;
    @(negedge clk);
    rx_drive = 1'b0;
    repeat (99) @(negedge clk);
    rx_drive = 1'b1;
    repeat (1200) @(negedge clk);
    check("glitch_no_rx_done", 32'(rx_done_cnt - base_rx), 32'd0);
    check("glitch_byte_held", 32'(data_out), 32'h3C);
    loop_en = 1'b1;
    repeat (20) @(negedge clk);

    // Reset during the data phase aborts both directions.
    base_rx = rx_done_cnt; base_tx = tx_done_cnt;
    send(8'h81, 2);
    repeat (1600) @(negedge clk);
    check("pre_reset_tx_low", 32'(tx_line), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("reset_mid_tx_line", 32'(tx_line), 32'd1);
    check("reset_mid_data_byte", 32'(data_out), 32'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (1200) @(negedge clk);
    check("abort_no_tx_done", 32'(tx_done_cnt - base_tx), 32'd0);
    check("abort_no_rx_done", 32'(rx_done_cnt - base_rx), 32'd0);
    rx_exp_q.push_back(8'hA5);
    send(8'hA5, 2);
    wait_rx(base_rx + 1, 5808, "a5_rx_done");
    wait_tx(base_tx + 1, 2000, "a5_tx_done");
    repeat (100) @(negedge clk);
    check("a5_data_byte", 32'(data_out), 32'hA5);
    check("rx_queue_empty", 32'(rx_exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLK_FREQ, 5000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, 9600, serial bit rate.
REQ-003 Parameter OVERSAMPLE, 16, ticks per bit.
REQ-004 Parameter DATA_BITS, 8, payload bits per frame.
REQ-005 Port i_clock  input  1  sole clock; all logic on rising edge.
REQ-006 Port i_reset  input  1  reset, asynchronous, active-high.
REQ-007 Port i_tx_signal  input  1  transmit request, level, sampled while TX idle.
REQ-008 Port i_data_byte  input  8  byte to transmit.
REQ-009 Port i_rx_data_input  input  1  serial receive line, idle high.
REQ-010 Port o_tick  output  1  oversample tick, one-clock pulse.
REQ-011 Port o_tx_data  output  1  serial transmit line, idle high.
REQ-012 Port o_done_bit_tx  output  1  one-clock pulse at end of transmitted frame.
REQ-013 Port o_done_bit_rx  output  1  one-clock pulse when a received byte is valid.
REQ-014 Port o_data_byte  output  8  last received byte, held until next reception.

Function
REQ-015 Frame SHALL be 8N1: start bit low, 8 data bits LSB first, one stop bit high, no parity.
REQ-016 Divisor SHALL be DIV = round(CLK_FREQ/(BAUD_RATE*OVERSAMPLE)) = 33 at defaults; the counter runs 0..DIV-1 free-running, and o_tick SHALL pulse high for one clock when the counter equals DIV-1.
REQ-017 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-018 In IDLE, with i_tx_signal=1, TX SHALL latch i_data_byte and enter START on the next clock.
REQ-019 START SHALL drive 0 for 16 ticks.
REQ-020 DATA SHALL drive each latched bit, bit0 first, for 16 ticks each.
REQ-021 STOP SHALL drive 1 for 16 ticks, then pulse o_done_bit_tx for one clock and return to IDLE.
REQ-022 i_tx_signal and i_data_byte changes while TX is not IDLE SHALL be ignored.
REQ-023 If i_tx_signal is still high when TX reaches IDLE, a new frame SHALL start.
REQ-024 RX SHALL pass i_rx_data_input through a 2-flop synchronizer before use.
REQ-025 RX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-026 IDLE->START SHALL occur on the synchronized line being 0.
REQ-027 START SHALL count 7 ticks (mid-bit); if the line is then 1, RX SHALL return to IDLE (glitch rejection), else enter DATA.
REQ-028 DATA SHALL sample every 16 ticks, shifting right (LSB first), for 8 bits.
REQ-029 STOP SHALL wait 16 ticks, then load o_data_byte and pulse o_done_bit_rx for one clock, then return to IDLE.
REQ-030 A stop bit sampled low SHALL still deliver the byte; no error flag.
REQ-031 TX and RX SHALL be independent; simultaneous operation SHALL be supported.
REQ-032 Loopback delivery (o_tx_data to i_rx_data_input) SHALL complete within 11 bit times (~1.15 ms at defaults) of the request.

Reset
REQ-033 i_reset SHALL asynchronously force: o_tx_data=1, o_tick=0, o_done_bit_tx=0, o_done_bit_rx=0, o_data_byte=0x00, divider and all tick/bit counters 0, both FSMs IDLE, synchronizer flops 1.
REQ-034 Reset asserted mid-frame SHALL abort the frame; no done pulse SHALL be produced for it.

Structure
REQ-035 Shared package SHALL hold the FSM state enums and the DIV/OVERSAMPLE/DATA_BITS constants.
REQ-036 Sub-modules SHALL be uart_baud_gen (tick), uart_tx and uart_rx, all sharing one o_tick.
REQ-037 uart_core SHALL be a thin top wiring these three sub-modules.

Verification
REQ-038 After reset, check idle state: o_tx_data=1, o_data_byte=0x00, done outputs 0; o_tick period = 33 clocks.
REQ-039 Loopback: i_data_byte=0xAA, i_tx_signal high for 50 clocks -> o_tx_data shows 0,0,1,0,1,0,1,0,1,1 at 16 ticks per bit; o_done_bit_tx pulses once; o_done_bit_rx pulses once; o_data_byte=0xAA within 11 bit times.
REQ-040 Back-to-back loopback of 0x00 then 0xFF -> o_data_byte 0x00 then 0xFF, one rx done pulse each.
REQ-041 Apply a 3-tick low glitch on i_rx_data_input -> RX returns to IDLE, no o_done_bit_rx.
REQ-042 Change i_data_byte to 0x55 mid-frame of a 0x3C transmission -> received byte is 0x3C.
REQ-043 Assert i_reset during DATA -> o_tx_data=1 immediately, no done pulses, next 0xA5 frame is received correctly.
